// File: rtl/baud_tick_ctrl.sv
// -----------------------------------------------------------------------------
// baud_tick_ctrl
//   Shared UART timing controller. A single programmable prescaler produces an
//   oversample tick; TX and RX keep their own phase counters on top of it to
//   produce the TX bit-boundary tick and the RX mid-bit sample strobe.
//
// Ports
//   clk        : system clock, all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   cfg_div    : requested divisor (clk cycles per oversample tick)
//   cfg_valid  : cfg_div is valid
//   cfg_ready  : divisor can be accepted this cycle (only while idle)
//   tx_en      : TX datapath requests bit timing
//   rx_en      : RX datapath requests sample timing
//   rx_resync  : single-cycle pulse on a detected RX start edge
//   ovs_tick   : one-cycle pulse every div_q clocks while running
//   tx_tick    : one-cycle pulse at every TX bit boundary
//   rx_sample  : one-cycle pulse at RX mid-bit
//   busy       : high while the prescaler runs
// -----------------------------------------------------------------------------
module baud_tick_ctrl #(
  parameter int DIV_W       = 16,
  parameter int OVS         = 16,
  parameter int DEFAULT_DIV = 326
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             tx_en,
  input  logic             rx_en,
  input  logic             rx_resync,
  output logic             ovs_tick,
  output logic             tx_tick,
  output logic             rx_sample,
  output logic             busy
);

  localparam int PH_W = $clog2(OVS);
  localparam logic [PH_W-1:0]  TX_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0]  RX_MID  = PH_W'(OVS / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  tx_ph_q, tx_ph_d;
  logic [PH_W-1:0]  rx_ph_q, rx_ph_d;
  logic             tx_en_q, tx_en_d;

  logic             busy_s;
  logic             cfg_ready_s;
  logic             ovs_tick_s;
  logic             tx_tick_s;
  logic             rx_sample_s;
  logic             stop_s;

  // A divisor below 2 cannot produce a distinct tick, so clamp it.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    if (d < DIV_MIN) begin
      clamp_div = DIV_MIN;
    end else begin
      clamp_div = d;
    end
  endfunction

  // Phase counters wrap modulo OVS, which need not be a power of two.
  function automatic logic [PH_W-1:0] ph_inc(input logic [PH_W-1:0] ph);
    if (ph == TX_LAST) begin
      ph_inc = {PH_W{1'b0}};
    end else begin
      ph_inc = ph + PH_W'(1);
    end
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: run whenever either datapath asks for timing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_en || rx_en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!tx_en && !rx_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode, purely from registers plus the enables/resync qualifiers.
  always_comb begin
    busy_s      = 1'b0;
    cfg_ready_s = 1'b1;
    ovs_tick_s  = 1'b0;
    case (state_q)
      ST_RUN: begin
        busy_s      = 1'b1;
        cfg_ready_s = 1'b0;
        ovs_tick_s  = (cnt_q == (div_q - DIV_W'(1)));
      end
      ST_IDLE: begin
        busy_s      = 1'b0;
        cfg_ready_s = 1'b1;
        ovs_tick_s  = 1'b0;
      end
      default: begin
        busy_s      = 1'b0;
        cfg_ready_s = 1'b1;
        ovs_tick_s  = 1'b0;
      end
    endcase
    tx_tick_s   = ovs_tick_s & tx_en & (tx_ph_q == TX_LAST);
    // A resync re-phases RX, so the coincident tick must not sample.
    rx_sample_s = ovs_tick_s & rx_en & ~rx_resync & (rx_ph_q == RX_MID);
  end

  // Datapath next-state: prescaler, phase counters, divisor handshake.
  always_comb begin
    stop_s  = (state_q == ST_RUN) & ~tx_en & ~rx_en;
    tx_en_d = tx_en;

    if ((state_q == ST_RUN) && !stop_s) begin
      if (ovs_tick_s) begin
        cnt_d = {DIV_W{1'b0}};
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d = {DIV_W{1'b0}};
    end

    // A fresh tx_en edge starts a new bit frame on the next oversample tick.
    if (stop_s || !tx_en || !tx_en_q) begin
      tx_ph_d = {PH_W{1'b0}};
    end else if (ovs_tick_s) begin
      tx_ph_d = ph_inc(tx_ph_q);
    end else begin
      tx_ph_d = tx_ph_q;
    end

    // The shared prescaler keeps running through a resync; only the phase moves.
    if (stop_s || !rx_en || rx_resync) begin
      rx_ph_d = {PH_W{1'b0}};
    end else if (ovs_tick_s) begin
      rx_ph_d = ph_inc(rx_ph_q);
    end else begin
      rx_ph_d = rx_ph_q;
    end

    if (cfg_valid && cfg_ready_s) begin
      div_d = clamp_div(cfg_div);
    end else begin
      div_d = div_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= {DIV_W{1'b0}};
      div_q   <= DIV_RST;
      tx_ph_q <= {PH_W{1'b0}};
      rx_ph_q <= {PH_W{1'b0}};
      tx_en_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tx_ph_q <= tx_ph_d;
      rx_ph_q <= rx_ph_d;
      tx_en_q <= tx_en_d;
    end
  end

  assign busy      = busy_s;
  assign cfg_ready = cfg_ready_s;
  assign ovs_tick  = ovs_tick_s;
  assign tx_tick   = tx_tick_s;
  assign rx_sample = rx_sample_s;

endmodule

// File: tb/tb_baud_tick_ctrl.sv
// -----------------------------------------------------------------------------
// tb_baud_tick_ctrl
//   Table of divisor configurations with expected tick spacing, hand-written
//   sequences for hold-off, resync and mid-run reset, and a randomized phase.
//   Every cycle is also compared against a cycle-count reference model.
// -----------------------------------------------------------------------------
module tb_baud_tick_ctrl;

  localparam int OVS  = 16;
  localparam int DDIV = 326;

  logic        clk;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        tx_en;
  logic        rx_en;
  logic        rx_resync;
  logic        ovs_tick;
  logic        tx_tick;
  logic        rx_sample;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: time measured as cycles since RUN began and ticks since
  // each phase origin; outputs follow from modulo arithmetic on those counts.
  bit m_run;
  int m_div;
  int m_elapsed;
  int m_txn;
  int m_rxn;
  bit m_tx_prev;

  // Sampled DUT outputs from the most recent cycle.
  logic s_ovs, s_tx, s_rx, s_busy, s_ready;

  baud_tick_ctrl #(.DIV_W(16), .OVS(OVS), .DEFAULT_DIV(DDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .tx_en     (tx_en),
    .rx_en     (rx_en),
    .rx_resync (rx_resync),
    .ovs_tick  (ovs_tick),
    .tx_tick   (tx_tick),
    .rx_sample (rx_sample),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_run     = 1'b0;
    m_div     = DDIV;
    m_elapsed = 0;
    m_txn     = 0;
    m_rxn     = 0;
    m_tx_prev = 1'b0;
  endtask

  // One clock cycle: compare at the falling edge, advance model at the rising edge.
  task automatic cycle();
    bit e_ovs, e_tx, e_rx;
    int d;
    @(negedge clk);
    e_ovs = m_run && ((m_elapsed % m_div) == m_div - 1);
    e_tx  = e_ovs && tx_en && ((m_txn % OVS) == OVS - 1);
    e_rx  = e_ovs && rx_en && !rx_resync && ((m_rxn % OVS) == OVS / 2 - 1);
    s_ovs = ovs_tick; s_tx = tx_tick; s_rx = rx_sample; s_busy = busy; s_ready = cfg_ready;
    chk("model_ovs_tick",  int'(ovs_tick),  int'(e_ovs));
    chk("model_tx_tick",   int'(tx_tick),   int'(e_tx));
    chk("model_rx_sample", int'(rx_sample), int'(e_rx));
    chk("model_busy",      int'(busy),      int'(m_run));
    chk("model_cfg_ready", int'(cfg_ready), int'(!m_run));
    @(posedge clk);
    if (!m_run && cfg_valid) begin
      d = int'(cfg_div);
      m_div = (d < 2) ? 2 : d;
    end
    if (!tx_en || !m_tx_prev) m_txn = 0;
    else if (e_ovs) m_txn++;
    if (!rx_en || rx_resync) m_rxn = 0;
    else if (e_ovs) m_rxn++;
    m_tx_prev = tx_en;
    if (!m_run) begin
      if (tx_en || rx_en) begin
        m_run = 1'b1;
        m_elapsed = 0;
      end
    end else if (!tx_en && !rx_en) begin
      m_run = 1'b0;
    end else begin
      m_elapsed++;
    end
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ovs_tick"},  int'(ovs_tick),  0);
    chk({tag, "_tx_tick"},   int'(tx_tick),   0);
    chk({tag, "_rx_sample"}, int'(rx_sample), 0);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
  endtask

  task automatic reset_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk_reset_outputs("rst_hold");
    end
  endtask

  task automatic go_idle();
    tx_en = 1'b0;
    rx_en = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic load_div(input logic [15:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    cycle();
    cfg_valid = 1'b0;
  endtask

  // Call with tx_en already raised; cycle indices count from the enable edge.
  task automatic measure_tx(input int max_cyc, output int first_ovs,
                            output int second_ovs, output int first_tx);
    first_ovs = -1; second_ovs = -1; first_tx = -1;
    cycle();
    for (int j = 1; j <= max_cyc && first_tx < 0; j++) begin
      cycle();
      if (s_ovs) begin
        if (first_ovs < 0) first_ovs = j;
        else if (second_ovs < 0) second_ovs = j;
      end
      if (s_tx && first_tx < 0) first_tx = j;
    end
  endtask

  // Counts oversample ticks after the current point until rx_sample fires.
  task automatic ticks_to_sample(output int n);
    int cnt;
    n = -1;
    cnt = 0;
    for (int j = 0; j < 400 && n < 0; j++) begin
      cycle();
      if (s_ovs) cnt++;
      if (s_rx) n = cnt;
    end
  endtask

  typedef struct {
    logic        load;
    logic [15:0] div_in;
    int          exp_period;
    int          exp_first_tx;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int f_ovs, s_ovs_i, f_tx, n, ticks;

    vecs[0] = '{1'b0, 16'd0, 326, 5216};
    vecs[1] = '{1'b1, 16'd4, 4, 64};
    vecs[2] = '{1'b1, 16'd0, 2, 32};
    vecs[3] = '{1'b1, 16'd1, 2, 32};
    vecs[4] = '{1'b1, 16'd5, 5, 80};
    vecs[5] = '{1'b1, 16'd3, 3, 48};

    rst_n = 1'b0; tx_en = 1'b1; rx_en = 1'b0; rx_resync = 1'b0;
    cfg_valid = 1'b0; cfg_div = 16'd0;
    m_reset();
    reset_hold(4);
    tx_en = 1'b0;
    rst_n = 1'b1;

    // Table: divisor in, expected tick spacing and first TX bit boundary out.
    for (int i = 0; i < 6; i++) begin
      go_idle();
      if (vecs[i].load) load_div(vecs[i].div_in);
      tx_en = 1'b1;
      measure_tx(6000, f_ovs, s_ovs_i, f_tx);
      chk($sformatf("vec%0d_first_ovs", i), f_ovs, vecs[i].exp_period);
      chk($sformatf("vec%0d_period", i), s_ovs_i - f_ovs, vecs[i].exp_period);
      chk($sformatf("vec%0d_first_tx", i), f_tx, vecs[i].exp_first_tx);
    end

    // Config and enable on the same edge: RUN uses the new divisor.
    go_idle();
    cfg_valid = 1'b1; cfg_div = 16'd6; tx_en = 1'b1;
    measure_tx(2000, f_ovs, s_ovs_i, f_tx);
    cfg_valid = 1'b0;
    chk("same_edge_period", s_ovs_i - f_ovs, 6);
    chk("same_edge_first_tx", f_tx, 96);

    // Reconfiguration requested in RUN is held off until idle.
    go_idle();
    load_div(16'd4);
    tx_en = 1'b1; rx_en = 1'b1;
    cycle(); cycle();
    cfg_valid = 1'b1; cfg_div = 16'd8;
    cycle();
    chk("holdoff_ready", int'(s_ready), 0);
    ticks = 0;
    for (int j = 0; j < 40; j++) begin
      cycle();
      if (s_ovs) ticks++;
    end
    chk("holdoff_ticks_in_40", ticks, 10);
    tx_en = 1'b0;
    cycle(); cycle();
    chk("one_enable_still_busy", int'(s_busy), 1);
    rx_en = 1'b0;
    cycle();
    cycle();
    chk("holdoff_ready_idle", int'(s_ready), 1);
    cfg_valid = 1'b0;
    tx_en = 1'b1;
    measure_tx(2000, f_ovs, s_ovs_i, f_tx);
    chk("after_holdoff_first_ovs", f_ovs, 8);
    chk("after_holdoff_period", s_ovs_i - f_ovs, 8);

    // RX resync: sample on the 8th tick after the pulse.
    go_idle();
    load_div(16'd4);
    rx_en = 1'b1;
    for (int j = 0; j < 10; j++) cycle();
    rx_resync = 1'b1;
    cycle();
    rx_resync = 1'b0;
    ticks_to_sample(n);
    chk("resync_ticks_to_sample", n, 8);
    // Resync landing exactly on a would-be sample tick.
    for (int j = 0; j < 200 && !rx_sample; j++) cycle();
    chk("resync_found_sample_tick", int'(rx_sample), 1);
    rx_resync = 1'b1;
    cycle();
    rx_resync = 1'b0;
    chk("resync_coincident_tick", int'(s_ovs), 1);
    chk("resync_coincident_no_sample", int'(s_rx), 0);
    ticks_to_sample(n);
    chk("resync_coincident_ticks_to_sample", n, 8);

    // Reset mid-run with tx_ph at 9.
    go_idle();
    load_div(16'd4);
    tx_en = 1'b1;
    cycle();
    ticks = 0;
    for (int j = 0; j < 200 && ticks < 9; j++) begin
      cycle();
      if (s_ovs) ticks++;
    end
    chk("midrun_ticks_before_reset", ticks, 9);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_rst");
    m_reset();
    tx_en = 1'b0;
    reset_hold(2);
    rst_n = 1'b1;
    cycle();
    tx_en = 1'b1;
    measure_tx(6000, f_ovs, s_ovs_i, f_tx);
    chk("post_reset_first_ovs", f_ovs, 326);
    chk("post_reset_first_tx", f_tx, 5216);

    // Randomized traffic checked cycle-by-cycle against the model.
    go_idle();
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 99) == 0) tx_en = ~tx_en;
      if ($urandom_range(0, 99) == 0) rx_en = ~rx_en;
      rx_resync = ($urandom_range(0, 19) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = 16'($urandom_range(0, 6));
      cycle();
    end
    rx_resync = 1'b0;
    cfg_valid = 1'b0;
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
